// File: rtl/caterr_pkg.sv
// Shared definitions for the CATERR filter controller: FSM states and default timing constants.
package caterr_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_WAIT_RST = 2'd1,
        ST_SETTLE   = 2'd2,
        ST_ARMED    = 2'd3
    } state_t;

    // 1 ms of stable-high CATERR at 2 MHz before the filter opens
    localparam int SETTLE_CNT_DEF = 2000;
    localparam int LEVEL_CNT_DEF  = 32;

endpackage

// File: rtl/caterr_filter_ctrl_if.sv
// Platform-side signal bundle of the CATERR filter controller.
// master drives power-good/reset/raw CATERR; slave (the controller) returns the qualified indications.
interface caterr_filter_ctrl_if;
    logic iCpuPwrgd;
    logic iPltRst_n;
    logic iCpuCatErr_n;
    logic oCatErrFilterEvent;
    logic oCatErrSync_n;
    logic oCatErrIerr;
    logic oCatErrMcerr;

    modport master (
        output iCpuPwrgd, iPltRst_n, iCpuCatErr_n,
        input  oCatErrFilterEvent, oCatErrSync_n, oCatErrIerr, oCatErrMcerr
    );

    modport slave (
        input  iCpuPwrgd, iPltRst_n, iCpuCatErr_n,
        output oCatErrFilterEvent, oCatErrSync_n, oCatErrIerr, oCatErrMcerr
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; reset value is a parameter.
// Latency 2 cycles; no backpressure.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iD,
    output logic oQ
);
    logic meta;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            meta <= RST_VAL;
            oQ   <= RST_VAL;
        end else begin
            meta <= iD;
            oQ   <= meta;
        end
    end
endmodule

// File: rtl/caterr_filter_ctrl.sv
// CATERR filter controller: opens the crashlog filter once CATERR is stably high after reset,
// optionally classifying low runs as IERR/MCERR (macro CATERR_CLASSIFY_EN). Latency: CATERR sync 2 cycles, outputs registered; no backpressure.
module caterr_filter_ctrl
    import caterr_pkg::*;
#(
    parameter int SETTLE_CNT = SETTLE_CNT_DEF,
    parameter int LEVEL_CNT  = LEVEL_CNT_DEF
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    caterr_filter_ctrl_if.slave  bus
);
    localparam int SW = $clog2(SETTLE_CNT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CNT - 1);

    if (SETTLE_CNT < 1 || LEVEL_CNT < 1) begin : gBadParam
        $error("caterr_filter_ctrl: SETTLE_CNT and LEVEL_CNT must be at least 1");
    end

    state_t          state, stateNext;
    logic [SW-1:0]   settleCnt, settleCntNext;
    logic            catErrSync_n;
    logic            filterEvent;

    sync_2ff #(.RST_VAL(1'b1)) uSync (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iD     (bus.iCpuCatErr_n),
        .oQ     (catErrSync_n)
    );

    always_comb begin
        stateNext     = state;
        settleCntNext = settleCnt;
        // Power-good loss outranks platform reset in the same cycle
        if (state != ST_OFF && !bus.iCpuPwrgd) begin
            stateNext = ST_OFF;
        end else begin
            case (state)
                ST_OFF:      if (bus.iCpuPwrgd) stateNext = ST_WAIT_RST;
                ST_WAIT_RST: if (bus.iPltRst_n) stateNext = ST_SETTLE;
                ST_SETTLE: begin
                    if (!bus.iPltRst_n)              stateNext = ST_WAIT_RST;
                    else if (!catErrSync_n)          settleCntNext = '0;
                    else if (settleCnt == SETTLE_LAST) stateNext = ST_ARMED;
                    else                             settleCntNext = settleCnt + SW'(1);
                end
                ST_ARMED:    if (!bus.iPltRst_n) stateNext = ST_WAIT_RST;
                default:     stateNext = ST_OFF;
            endcase
        end
        if (stateNext != ST_SETTLE) settleCntNext = '0;
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state       <= ST_OFF;
            settleCnt   <= '0;
            filterEvent <= 1'b0;
        end else begin
            state       <= stateNext;
            settleCnt   <= settleCntNext;
            filterEvent <= (stateNext == ST_ARMED);
        end
    end

    assign bus.oCatErrFilterEvent = filterEvent;
    assign bus.oCatErrSync_n      = catErrSync_n;

`ifdef CATERR_CLASSIFY_EN
    localparam int LW = $clog2(LEVEL_CNT + 1);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(LEVEL_CNT);
    localparam logic [LW-1:0] LEVEL_PRE = LW'(LEVEL_CNT - 1);

    logic [LW-1:0] lowCnt;
    logic          ierr;
    logic          mcerr;
    logic          keepArmed;

    // A run still open when the filter closes is dropped without classification
    assign keepArmed = (state == ST_ARMED) && (stateNext == ST_ARMED);

    always_ff @(posedge iClk) begin
        if (!iRst_n || !keepArmed) begin
            lowCnt <= '0;
            ierr   <= 1'b0;
            mcerr  <= 1'b0;
        end else if (!catErrSync_n) begin
            if (lowCnt != LEVEL_MAX) lowCnt <= lowCnt + LW'(1);
            if (lowCnt == LEVEL_PRE) ierr <= 1'b1;
            mcerr <= 1'b0;
        end else begin
            mcerr  <= (lowCnt != '0) && (lowCnt != LEVEL_MAX);
            lowCnt <= '0;
        end
    end

    assign bus.oCatErrIerr  = ierr;
    assign bus.oCatErrMcerr = mcerr;
`else
    assign bus.oCatErrIerr  = 1'b0;
    assign bus.oCatErrMcerr = 1'b0;
`endif

endmodule

// File: tb/tb_caterr_filter_ctrl.sv
// Bench for caterr_filter_ctrl: directed scenarios with literal timing expectations, then randomized
// traffic checked every cycle against a behavioural model of the filter rules.
module tb_caterr_filter_ctrl;
    localparam int SETTLE = 16;
    localparam int LEVEL  = 4;
`ifdef CATERR_CLASSIFY_EN
    localparam bit CLS = 1'b1;
`else
    localparam bit CLS = 1'b0;
`endif
    localparam int P_OFF = 0, P_WAIT = 1, P_SETTLE = 2, P_ARMED = 3;

    logic clk;
    logic rst_n;
    int   vecs = 0;
    int   errs = 0;

    caterr_filter_ctrl_if bus ();
    caterr_filter_ctrl_if busD ();

    caterr_filter_ctrl #(.SETTLE_CNT(SETTLE), .LEVEL_CNT(LEVEL)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus.slave)
    );

    caterr_filter_ctrl dutDflt (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (busD.slave)
    );

    assign busD.iCpuPwrgd    = bus.iCpuPwrgd;
    assign busD.iPltRst_n    = bus.iPltRst_n;
    assign busD.iCpuCatErr_n = bus.iCpuCatErr_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase, length of the high run counted while settling, length of the current low run
    int mPhase = P_OFF;
    int mSettle = 0;
    int mLow = 0;
    int mIerr = 0;
    int mMcerr = 0;
    int q1 = 1, q2 = 1;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            mPhase = P_OFF; mSettle = 0; mLow = 0; mIerr = 0; mMcerr = 0; q1 = 1; q2 = 1;
        end else begin
            int s, prev;
            s = q2;
            prev = mPhase;
            if (mPhase != P_OFF && !bus.iCpuPwrgd) mPhase = P_OFF;
            else if (mPhase == P_OFF) begin
                if (bus.iCpuPwrgd) mPhase = P_WAIT;
            end else if (mPhase == P_WAIT) begin
                if (bus.iPltRst_n) begin mPhase = P_SETTLE; mSettle = 0; end
            end else if (!bus.iPltRst_n) mPhase = P_WAIT;
            else if (mPhase == P_SETTLE) begin
                if (s == 0) mSettle = 0;
                else begin
                    mSettle++;
                    if (mSettle == SETTLE) mPhase = P_ARMED;
                end
            end
            if (prev == P_ARMED && mPhase == P_ARMED) begin
                if (s == 0) begin
                    mLow = (mLow + 1 > LEVEL) ? LEVEL : mLow + 1;
                    if (mLow >= LEVEL) mIerr = 1;
                    mMcerr = 0;
                end else begin
                    mMcerr = (mLow > 0 && mLow < LEVEL) ? 1 : 0;
                    mLow = 0;
                end
            end else begin
                mLow = 0; mIerr = 0; mMcerr = 0;
            end
            q2 = q1;
            q1 = int'(bus.iCpuCatErr_n);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        chk("sync", int'(bus.oCatErrSync_n), q2);
        chk("filter", int'(bus.oCatErrFilterEvent), (mPhase == P_ARMED) ? 1 : 0);
        chk("ierr", int'(bus.oCatErrIerr), CLS ? mIerr : 0);
        chk("mcerr", int'(bus.oCatErrMcerr), CLS ? mMcerr : 0);
    end

    // Event markers: first cycle (counted from clearMarks) each output was seen high
    int k, fFirst, dFirst, mFirst, mCount, iFirst;

    task automatic clearMarks();
        k = 0; fFirst = -1; dFirst = -1; mFirst = -1; mCount = 0; iFirst = -1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.oCatErrFilterEvent && fFirst < 0) fFirst = k;
            if (busD.oCatErrFilterEvent && dFirst < 0) dFirst = k;
            if (bus.oCatErrMcerr) begin
                if (mFirst < 0) mFirst = k;
                mCount++;
            end
            if (bus.oCatErrIerr && iFirst < 0) iFirst = k;
        end
    endtask

    initial begin
        int runLeft;
        rst_n = 1'b0;
        bus.iCpuPwrgd = 1'b0;
        bus.iPltRst_n = 1'b0;
        bus.iCpuCatErr_n = 1'b1;
        clearMarks();
        run(3);
        chk("rst_sync", int'(bus.oCatErrSync_n), 1);
        chk("rst_filter", int'(bus.oCatErrFilterEvent), 0);
        chk("rst_ierr", int'(bus.oCatErrIerr), 0);
        chk("rst_mcerr", int'(bus.oCatErrMcerr), 0);

        // Power up, then release platform reset with CATERR high
        @(negedge clk); rst_n = 1'b1; bus.iCpuPwrgd = 1'b1;
        run(3);
        clearMarks();
        @(negedge clk); bus.iPltRst_n = 1'b1;
        run(2005);
        chk("settle_latency", fFirst, 17);
        chk("settle_latency_default", dFirst, 2001);

        // Short low pulse while armed
        clearMarks();
        @(negedge clk); bus.iCpuCatErr_n = 1'b0;
        run(2);
        @(negedge clk); bus.iCpuCatErr_n = 1'b1;
        run(10);
        chk("mcerr_cycle", mFirst, CLS ? 5 : -1);
        chk("mcerr_width", mCount, CLS ? 1 : 0);
        chk("mcerr_no_ierr", iFirst, -1);

        // Long low level while armed
        clearMarks();
        @(negedge clk); bus.iCpuCatErr_n = 1'b0;
        run(10);
        @(negedge clk); bus.iCpuCatErr_n = 1'b1;
        run(6);
        chk("ierr_cycle", iFirst, CLS ? 6 : -1);
        chk("ierr_no_mcerr", mCount, 0);
        chk("ierr_held", int'(bus.oCatErrIerr), CLS ? 1 : 0);
        chk("armed_through_ierr", fFirst, 1);
        @(negedge clk); bus.iPltRst_n = 1'b0;
        run(1);
        chk("ierr_clear_on_rst", int'(bus.oCatErrIerr), 0);
        chk("filter_drop_on_rst", int'(bus.oCatErrFilterEvent), 0);

        // Glitch during settling restarts the count
        @(negedge clk); bus.iPltRst_n = 1'b1;
        run(11);
        @(negedge clk); bus.iCpuCatErr_n = 1'b0;
        run(3);
        clearMarks();
        @(negedge clk); bus.iCpuCatErr_n = 1'b1;
        run(25);
        chk("settle_restart", fFirst, 18);

        // Power-good and platform reset drop together while armed
        @(negedge clk); bus.iCpuPwrgd = 1'b0; bus.iPltRst_n = 1'b0;
        run(1);
        chk("pwrgd_drop_filter", int'(bus.oCatErrFilterEvent), 0);
        @(negedge clk); bus.iCpuPwrgd = 1'b1;
        run(2);
        @(negedge clk); bus.iPltRst_n = 1'b1;
        run(5);
        @(negedge clk); bus.iCpuCatErr_n = 1'b0;
        run(3);
        chk("sync_low_before_rst", int'(bus.oCatErrSync_n), 0);
        @(negedge clk); rst_n = 1'b0;
        run(1);
        chk("midrst_sync", int'(bus.oCatErrSync_n), 1);
        chk("midrst_filter", int'(bus.oCatErrFilterEvent), 0);
        chk("midrst_ierr", int'(bus.oCatErrIerr), 0);
        chk("midrst_mcerr", int'(bus.oCatErrMcerr), 0);
        @(negedge clk); rst_n = 1'b1; bus.iCpuCatErr_n = 1'b1;

        // Randomized traffic with mostly-stable power/reset and mixed CATERR run lengths
        runLeft = 40;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (runLeft == 0) begin
                bus.iCpuCatErr_n = ~bus.iCpuCatErr_n;
                if (bus.iCpuCatErr_n) runLeft = int'($urandom_range(1, 40));
                else if ($urandom_range(0, 3) == 0) runLeft = int'($urandom_range(4, 12));
                else runLeft = int'($urandom_range(1, 4));
            end
            runLeft--;
            if (bus.iCpuPwrgd && $urandom_range(0, 299) == 0) bus.iCpuPwrgd = 1'b0;
            else if (!bus.iCpuPwrgd && $urandom_range(0, 9) == 0) bus.iCpuPwrgd = 1'b1;
            if (bus.iPltRst_n && $urandom_range(0, 199) == 0) bus.iPltRst_n = 1'b0;
            else if (!bus.iPltRst_n && $urandom_range(0, 5) == 0) bus.iPltRst_n = 1'b1;
            rst_n = ($urandom_range(0, 999) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/caterr_filter_ctrl.md
CATERR_FILTER_CTRL -- requirements
Module: caterr_filter_ctrl

Interface
REQ-001 Parameter SETTLE_CNT, default 2000, iClk cycles CATERR must stay stably high after platform reset release before filter opens (1 ms at 2 MHz).
REQ-002 Parameter LEVEL_CNT, default 32, consecutive low cycles that classify CATERR as level (IERR) rather than pulse (MCERR).
REQ-003 iClk  input  1  block clock; the only clock.
REQ-004 iRst_n  input  1  reset; synchronous, active-low.
REQ-005 iCpuPwrgd  input  1  CPU power-good, synchronous to iClk.
REQ-006 iPltRst_n  input  1  platform reset, active-low, synchronous to iClk.
REQ-007 iCpuCatErr_n  input  1  raw wired-AND CPU CATERR, asynchronous, active-low.
REQ-008 oCatErrFilterEvent  output  1  high while CATERR is qualified; drives the CATERR/crashlog glue logic filter input.
REQ-009 oCatErrSync_n  output  1  synchronized CATERR, active-low.
REQ-010 oCatErrIerr  output  1  sticky level-CATERR indication.
REQ-011 oCatErrMcerr  output  1  one-cycle pulse-CATERR indication.

Function
REQ-012 iCpuCatErr_n SHALL pass a 2-flop synchronizer; oCatErrSync_n SHALL equal iCpuCatErr_n delayed by exactly 2 iClk cycles.
REQ-013 FSM states SHALL be ST_OFF, ST_WAIT_RST, ST_SETTLE, ST_ARMED.
REQ-014 ST_OFF -> ST_WAIT_RST when iCpuPwrgd=1.
REQ-015 ST_WAIT_RST -> ST_SETTLE with settle counter cleared when iPltRst_n=1.
REQ-016 ST_SETTLE: counter increments each cycle oCatErrSync_n=1; clears to 0 on any cycle oCatErrSync_n=0; -> ST_ARMED the cycle counter equals SETTLE_CNT-1 with oCatErrSync_n=1.
REQ-017 ST_SETTLE/ST_ARMED -> ST_WAIT_RST when iPltRst_n=0.
REQ-018 Any non-OFF state -> ST_OFF when iCpuPwrgd=0; power-good loss has priority over reset assertion in the same cycle.
REQ-019 oCatErrFilterEvent SHALL be registered, high exactly in cycles where the state register is ST_ARMED (one cycle after the transition decision).
REQ-020 Settle counter width SHALL be $clog2(SETTLE_CNT+1); it SHALL never wrap; SETTLE_CNT=1 arms after one high cycle.
REQ-021 Classifier, active only in ST_ARMED: saturating low-run counter increments while oCatErrSync_n=0, clears when 1.
REQ-022 oCatErrIerr SHALL set the cycle the low-run count reaches LEVEL_CNT and hold until the state leaves ST_ARMED.
REQ-023 oCatErrMcerr SHALL pulse for one cycle on the rising edge of oCatErrSync_n when the preceding low run was 1..LEVEL_CNT-1 cycles; no pulse after an IERR-length run.
REQ-024 A low run in progress when the state leaves ST_ARMED SHALL be discarded: no MCERR pulse, low-run counter cleared.

Reset
REQ-025 With iRst_n=0 at a rising iClk edge: state ST_OFF, all counters 0, synchronizer flops 1, oCatErrSync_n=1, oCatErrFilterEvent=0, oCatErrIerr=0, oCatErrMcerr=0.
REQ-026 Reset mid-operation (any state) SHALL take effect on the next edge with no residual outputs.

Configuration
REQ-027 Macro CATERR_CLASSIFY_EN: when defined, REQ-021..REQ-024 classifier logic is compiled in; when undefined, no classifier registers exist and oCatErrIerr, oCatErrMcerr are tied 0; all other behaviour is identical.

Structure
REQ-028 FSM state enum, default SETTLE_CNT/LEVEL_CNT constants SHALL live in shared package caterr_pkg.
REQ-029 The synchronizer SHALL be sub-module sync_2ff (1-bit, reset value parameterized, here 1).

Verification (SETTLE_CNT=16, LEVEL_CNT=4 overrides unless noted)
REQ-030 Pwrgd=1, PltRst_n=1, CATERR high -> oCatErrFilterEvent rises 17 cycles after PltRst_n rises (1 WAIT_RST + 16 settle); default params -> 2001 cycles.
REQ-031 CATERR low 3 cycles at settle count 10 -> counter restarts; filter event rises 16 cycles after CATERR returns high as seen on oCatErrSync_n.
REQ-032 Armed, CATERR low 2 cycles -> oCatErrMcerr single-cycle pulse 1 cycle after oCatErrSync_n rises; oCatErrIerr stays 0.
REQ-033 Armed, CATERR low 10 cycles -> oCatErrIerr sets on 4th low cycle of oCatErrSync_n, no MCERR; clears when PltRst_n drops; filter event 0 next cycle.
REQ-034 Armed, Pwrgd and PltRst_n drop same cycle -> state ST_OFF, filter event 0; reassert iRst_n=0 in ST_SETTLE -> all outputs reset values next edge.
REQ-035 Build without CATERR_CLASSIFY_EN, repeat REQ-032/033 stimulus -> oCatErrIerr=oCatErrMcerr=0, filter timing unchanged.
